// File: rtl/dds_ctrl_pkg.sv
// Shared definitions for the DDS sweep controller: FSM states, mode codes and
// default sweep constants.
package dds_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MANUAL  = 3'd1,
    ST_RAMP_UP = 3'd2,
    ST_RAMP_DN = 3'd3,
    ST_TRI     = 3'd4,
    ST_PEND    = 3'd5
  } state_t;

  localparam logic [1:0] MODE_MANUAL  = 2'b00;
  localparam logic [1:0] MODE_RAMP_UP = 2'b01;
  localparam logic [1:0] MODE_RAMP_DN = 2'b10;
  localparam logic [1:0] MODE_TRI     = 2'b11;

  localparam logic [31:0] F_MIN_DEF     = 32'd3000;
  localparam logic [31:0] F_MAX_DEF     = 32'd8_000_100;
  localparam logic [31:0] F_STEP_DEF    = 32'd100;
  localparam logic [23:0] DWELL_CYC_DEF = 24'd24_000;

  function automatic state_t mode_state(input logic [1:0] mode);
    case (mode)
      MODE_RAMP_UP: return ST_RAMP_UP;
      MODE_RAMP_DN: return ST_RAMP_DN;
      MODE_TRI:     return ST_TRI;
      default:      return ST_MANUAL;
    endcase
  endfunction

  function automatic logic is_sweep(input state_t s);
    return (s == ST_RAMP_UP) || (s == ST_RAMP_DN) || (s == ST_TRI);
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter for sweep steps: tick marks the last cycle of a dwell period,
// after which the count restarts at zero. Holding en low freezes the count.
module dwell_timer
  import dds_ctrl_pkg::*;
#(
  parameter logic [23:0] DWELL_CYC = DWELL_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  logic [23:0] cnt;

  assign tick = en && (cnt == DWELL_CYC - 24'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 24'd1;
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-word sweep controller: manual stepping, ramp up/down and triangle
// sweeps, each new word offered to the phase accumulator via valid/ready.
module dds_sweep_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter logic [31:0] F_MIN     = F_MIN_DEF,
  parameter logic [31:0] F_MAX     = F_MAX_DEF,
  parameter logic [31:0] F_STEP    = F_STEP_DEF,
  parameter logic [23:0] DWELL_CYC = DWELL_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [1:0]  mode,
  input  logic        key_up,
  input  logic        key_dn,
  output logic [31:0] fword,
  output logic        upd_valid,
  input  logic        upd_ready,
  output logic        sweep_active,
  output logic        wrap_led
);

  localparam logic [32:0] MAX_33      = {1'b0, F_MAX};
  localparam logic [32:0] MIN_STEP_33 = {1'b0, F_MIN} + {1'b0, F_STEP};

  state_t      state, state_nx, ret_state, ret_nx, tgt;
  logic        dir_up, dir_nx;
  logic        load, wrap_ev;
  logic [31:0] word_nx;
  logic        tmr_clr, tmr_en, tick;
  logic        upd_valid_nx, sweep_active_nx, wrap_led_nx;

  // All bound compares are done on 33-bit extended operands.
  function automatic logic [32:0] up_sum(input logic [31:0] cur);
    return {1'b0, cur} + {1'b0, F_STEP};
  endfunction

  function automatic logic [31:0] sat_up(input logic [31:0] cur);
    return (up_sum(cur) > MAX_33) ? F_MAX : cur + F_STEP;
  endfunction

  function automatic logic [31:0] sat_dn(input logic [31:0] cur);
    return ({1'b0, cur} < MIN_STEP_33) ? F_MIN : cur - F_STEP;
  endfunction

  assign tgt    = mode_state(mode);
  assign tmr_en = is_sweep(state) && run && (tgt == state);

  dwell_timer #(
    .DWELL_CYC (DWELL_CYC)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ret_state <= ST_IDLE;
    end else begin
      state     <= state_nx;
      ret_state <= ret_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ret_nx   = ret_state;
    dir_nx   = dir_up;
    word_nx  = fword;
    load     = 1'b0;
    wrap_ev  = 1'b0;
    tmr_clr  = 1'b0;
    case (state)
      ST_PEND: begin
        if (upd_ready) state_nx = run ? ret_state : ST_IDLE;
      end
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (run) begin
          state_nx = tgt;
          dir_nx   = 1'b1;
        end
      end
      default: begin
        if (!run) begin
          state_nx = ST_IDLE;
          tmr_clr  = 1'b1;
        end else if (tgt != state) begin
          state_nx = tgt;
          tmr_clr  = 1'b1;
          dir_nx   = 1'b1;
        end else begin
          case (state)
            ST_MANUAL: begin
              if (key_up != key_dn) begin
                load    = 1'b1;
                word_nx = key_up ? sat_up(fword) : sat_dn(fword);
              end
            end
            ST_RAMP_UP: begin
              if (tick) begin
                load    = 1'b1;
                wrap_ev = up_sum(fword) > MAX_33;
                word_nx = wrap_ev ? F_MIN : fword + F_STEP;
              end
            end
            ST_RAMP_DN: begin
              if (tick) begin
                load    = 1'b1;
                wrap_ev = {1'b0, fword} < MIN_STEP_33;
                word_nx = wrap_ev ? F_MAX : fword - F_STEP;
              end
            end
            ST_TRI: begin
              // Reverse on the step that lands on (or would pass) a bound, so
              // the extreme word is emitted exactly once per reversal.
              if (tick) begin
                load = 1'b1;
                if (dir_up) begin
                  wrap_ev = up_sum(fword) >= MAX_33;
                  word_nx = wrap_ev ? F_MAX : fword + F_STEP;
                end else begin
                  wrap_ev = {1'b0, fword} <= MIN_STEP_33;
                  word_nx = wrap_ev ? F_MIN : fword - F_STEP;
                end
                if (wrap_ev) dir_nx = !dir_up;
              end
            end
            default: ;
          endcase
          if (load) begin
            state_nx = ST_PEND;
            ret_nx   = state;
          end
        end
      end
    endcase
  end

  // A pending update made on behalf of a sweep still counts as sweeping.
  always_comb begin
    upd_valid_nx    = (state_nx == ST_PEND);
    sweep_active_nx = is_sweep(state_nx) || ((state_nx == ST_PEND) && is_sweep(ret_nx));
    wrap_led_nx     = wrap_led ^ wrap_ev;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fword        <= F_MIN;
      upd_valid    <= 1'b0;
      sweep_active <= 1'b0;
      wrap_led     <= 1'b0;
      dir_up       <= 1'b1;
    end else begin
      if (load) fword <= word_nx;
      upd_valid    <= upd_valid_nx;
      sweep_active <= sweep_active_nx;
      wrap_led     <= wrap_led_nx;
      dir_up       <= dir_nx;
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl with a short dwell; expected words come from an
// arithmetic model of the sweep rules kept in the bench.
module tb_dds_sweep_ctrl;

  localparam longint FMIN  = 3000;
  localparam longint FMAX  = 8_000_100;
  localparam longint FSTEP = 100;
  localparam int     DWELL = 4;

  logic        clk = 1'b0;
  logic        rst_n, run, key_up, key_dn, upd_ready;
  logic [1:0]  mode;
  logic [31:0] fword;
  logic        upd_valid, sweep_active, wrap_led;

  int     errors = 0;
  int     checks = 0;
  longint exp_word;
  bit     exp_led;
  bit     exp_up;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(
    .DWELL_CYC (24'd4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .mode         (mode),
    .key_up       (key_up),
    .key_dn       (key_dn),
    .fword        (fword),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .sweep_active (sweep_active),
    .wrap_led     (wrap_led)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_key(input bit up, input bit dn);
    if (up && !dn)      exp_word = (exp_word + FSTEP > FMAX) ? FMAX : exp_word + FSTEP;
    else if (dn && !up) exp_word = (exp_word - FSTEP < FMIN) ? FMIN : exp_word - FSTEP;
  endtask

  task automatic model_sweep(input int md);
    case (md)
      1: if (exp_word + FSTEP > FMAX) begin exp_word = FMIN; exp_led = !exp_led; end
         else exp_word = exp_word + FSTEP;
      2: if (exp_word - FSTEP < FMIN) begin exp_word = FMAX; exp_led = !exp_led; end
         else exp_word = exp_word - FSTEP;
      default: begin
        if (exp_up) begin
          if (exp_word + FSTEP >= FMAX) begin exp_word = FMAX; exp_up = 0; exp_led = !exp_led; end
          else exp_word = exp_word + FSTEP;
        end else begin
          if (exp_word - FSTEP <= FMIN) begin exp_word = FMIN; exp_up = 1; exp_led = !exp_led; end
          else exp_word = exp_word - FSTEP;
        end
      end
    endcase
  endtask

  task automatic key_pulse(input bit up, input bit dn);
    key_up = up;
    key_dn = dn;
    step();
    key_up = 1'b0;
    key_dn = 1'b0;
  endtask

  task automatic wait_upd(input string tag, output int n);
    n = 0;
    while (upd_valid !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, upd_valid, 1'b1);
  endtask

  task automatic sweep_next(input string tag, input int md, input bit timed);
    int n;
    step();
    if (timed) chk({tag, "_active"}, sweep_active, 1'b1);
    wait_upd(tag, n);
    // After a handshake the ramp dwells DWELL cycles before the next word.
    if (timed) chk({tag, "_period"}, n, DWELL);
    model_sweep(md);
    chk({tag, "_word"}, fword, exp_word[31:0]);
    chk({tag, "_led"}, wrap_led, exp_led);
  endtask

  initial begin
    rst_n = 1'b1; run = 1'b0; mode = 2'b00;
    key_up = 1'b0; key_dn = 1'b0; upd_ready = 1'b1;
    exp_word = FMIN; exp_led = 0; exp_up = 1;
    #2 rst_n = 1'b0;
    repeat (3) step();
    chk("rst_word", fword, exp_word[31:0]);
    chk("rst_valid", upd_valid, 1'b0);
    chk("rst_active", sweep_active, 1'b0);
    chk("rst_led", wrap_led, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      key_up = i[0];
      step();
      chk("norun_quiet", upd_valid, 1'b0);
    end
    key_up = 1'b0;

    // Manual stepping and saturation at the low bound
    run = 1'b1; mode = 2'b00;
    step();
    key_pulse(1, 0); model_key(1, 0);
    chk("man_up_valid", upd_valid, 1'b1);
    chk("man_up_word", fword, exp_word[31:0]);
    step();
    chk("man_up_once", upd_valid, 1'b0);
    key_pulse(0, 1); model_key(0, 1);
    chk("man_dn_word", fword, exp_word[31:0]);
    step();
    key_pulse(0, 1); model_key(0, 1);
    chk("sat_min_valid", upd_valid, 1'b1);
    chk("sat_min_word", fword, exp_word[31:0]);
    step();
    key_pulse(1, 1);
    chk("both_keys", upd_valid, 1'b0);
    step();
    chk("both_keys_late", upd_valid, 1'b0);

    // Ramp down from F_MIN wraps to F_MAX
    mode = 2'b10;
    sweep_next("rd_wrap", 2, 0);
    mode = 2'b00;
    step();
    step();
    chk("manual_inactive", sweep_active, 1'b0);
    key_pulse(1, 0); model_key(1, 0);
    chk("sat_max_valid", upd_valid, 1'b1);
    chk("sat_max_word", fword, exp_word[31:0]);
    step();
    chk("sat_max_once", upd_valid, 1'b0);
    key_pulse(0, 1); model_key(0, 1);
    chk("man_dn_top", fword, exp_word[31:0]);
    step();

    // Ramp up across F_MAX, then back down to reach the triangle start point
    mode = 2'b01;
    sweep_next("ru_top", 1, 0);
    sweep_next("ru_wrap", 1, 1);
    mode = 2'b10;
    sweep_next("rd_wrap2", 2, 0);
    sweep_next("rd_step", 2, 1);
    mode = 2'b11; exp_up = 1;
    sweep_next("tri_peak", 3, 0);
    sweep_next("tri_rev", 3, 1);

    // Backpressure during the triangle sweep
    step();
    upd_ready = 1'b0;
    begin
      int n;
      wait_upd("bp", n);
    end
    model_sweep(3);
    chk("bp_word", fword, exp_word[31:0]);
    for (int i = 0; i < 10; i++) begin
      key_up = 1'($urandom_range(0, 1));
      key_dn = 1'($urandom_range(0, 1));
      step();
      chk("bp_hold_valid", upd_valid, 1'b1);
      chk("bp_hold_word", fword, exp_word[31:0]);
    end
    key_up = 1'b0; key_dn = 1'b0;
    upd_ready = 1'b1;
    sweep_next("tri_resume", 3, 1);

    // Key pulses arriving while a manual update is pending are dropped
    mode = 2'b00;
    step();
    step();
    upd_ready = 1'b0;
    key_pulse(1, 0); model_key(1, 0);
    chk("mp_word", fword, exp_word[31:0]);
    for (int i = 0; i < 5; i++) begin
      key_up = i[0];
      key_dn = !i[0];
      step();
      chk("mp_hold_valid", upd_valid, 1'b1);
      chk("mp_hold_word", fword, exp_word[31:0]);
    end
    key_up = 1'b0; key_dn = 1'b0;
    upd_ready = 1'b1;
    step();
    chk("mp_drop", upd_valid, 1'b0);
    step();
    chk("mp_no_extra", upd_valid, 1'b0);
    chk("mp_final_word", fword, exp_word[31:0]);

    // Random manual key traffic, biased upward to reach saturation
    for (int i = 0; i < 24; i++) begin
      int r;
      bit ku, kd;
      r  = $urandom_range(0, 5);
      ku = (r >= 1 && r <= 3) || (r == 5);
      kd = (r == 4) || (r == 5);
      key_pulse(ku, kd);
      chk("rnd_valid", upd_valid, 1'(ku ^ kd));
      if (ku ^ kd) begin
        model_key(ku, kd);
        chk("rnd_word", fword, exp_word[31:0]);
      end
      step();
      chk("rnd_idle", upd_valid, 1'b0);
    end

    // Reset while an update is pending
    upd_ready = 1'b0;
    key_pulse(1, 0);
    chk("pre_rst_valid", upd_valid, 1'b1);
    #3 rst_n = 1'b0;
    run = 1'b0;
    #1;
    exp_word = FMIN; exp_led = 0; exp_up = 1;
    chk("async_rst_valid", upd_valid, 1'b0);
    chk("async_rst_word", fword, exp_word[31:0]);
    chk("async_rst_led", wrap_led, 1'b0);
    chk("async_rst_active", sweep_active, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    upd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      key_up = 1'($urandom_range(0, 1));
      mode = 2'($urandom_range(0, 3));
      step();
      chk("post_rst_quiet", upd_valid, 1'b0);
    end
    key_up = 1'b0;
    run = 1'b1; mode = 2'b00;
    step();
    key_pulse(1, 0); model_key(1, 0);
    chk("post_rst_valid", upd_valid, 1'b1);
    chk("post_rst_word", fword, exp_word[31:0]);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
